// File: rtl/arrow_if.sv
// arrow_if: link between the spawner and the downstream arrow stage.
// The master side drives launch requests; the slave side returns the hit flag.
interface arrow_if;
    logic       valid_out;
    logic [1:0] direction_out;
    logic [2:0] speed_out;
    logic       inversed_out;
    logic       arrow_hit_in;

    modport master (
        output valid_out,
        output direction_out,
        output speed_out,
        output inversed_out,
        input  arrow_hit_in
    );

    modport slave (
        input  valid_out,
        input  direction_out,
        input  speed_out,
        input  inversed_out,
        output arrow_hit_in
    );
endinterface

// File: rtl/arrow_spawner.sv
// arrow_spawner: launch sequencer for one arrow slot (IDLE -> GAP -> LAUNCH -> FLIGHT).
// Define ARROW_SPAWNER_INVERSE_EN to enable inverse-trajectory requests.
module arrow_spawner #(
    parameter int unsigned GAP_FRAMES        = 30,
    parameter int unsigned MIN_GAP           = 8,
    parameter int unsigned SPEEDUP_EVERY     = 8,
    parameter int unsigned MAX_FLIGHT_FRAMES = 240,
    parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        start_in,
    arrow_if.master     arrow,
    output logic [7:0]  spawn_count
);
    typedef enum logic [1:0] {IDLE, GAP, LAUNCH, FLIGHT} state_e;

    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [8:0]  GAP_BASE     = 9'(GAP_FRAMES);
    localparam logic [8:0]  GAP_FLOOR    = 9'(MIN_GAP);
    localparam logic [7:0]  SPEEDUP_LAST = 8'(SPEEDUP_EVERY - 1);
    localparam logic [7:0]  FLIGHT_MAX   = 8'(MAX_FLIGHT_FRAMES);
    localparam logic [2:0]  SPEED_TOP    = 3'd7;

    state_e      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [8:0]  gap_cnt_q, gap_cnt_d;
    logic [7:0]  flight_cnt_q, flight_cnt_d;
    logic        launch_clk_q, launch_clk_d;
    logic [7:0]  launch_mod_q, launch_mod_d;
    logic        valid_q, valid_d;
    logic [1:0]  dir_q, dir_d;
    logic [2:0]  speed_q, speed_d;
    logic [7:0]  spawn_q, spawn_d;
`ifdef ARROW_SPAWNER_INVERSE_EN
    logic        inv_q, inv_d;
`endif

    logic        frame_tick;
    logic        enter_gap;
    logic        enter_launch;
    logic [8:0]  two_speed;
    logic [8:0]  gap_raw;
    logic [8:0]  gap_len;

    assign frame_tick = (hcount_in == 11'd0) && (vcount_in == 10'd0);

    // Shrinking gap; the comparison catches the 9-bit wrap when 2*speed exceeds the base.
    assign two_speed = {5'd0, speed_q, 1'b0};
    assign gap_raw   = GAP_BASE - two_speed;
    assign gap_len   = ((two_speed > GAP_BASE) || (gap_raw < GAP_FLOOR)) ? GAP_FLOOR : gap_raw;

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through the block infers a latch.
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        flight_cnt_d = flight_cnt_q;
        launch_clk_d = launch_clk_q;
        launch_mod_d = launch_mod_q;
        valid_d      = valid_q;
        dir_d        = dir_q;
        speed_d      = speed_q;
        spawn_d      = spawn_q;
        enter_gap    = 1'b0;
        enter_launch = 1'b0;
        lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
`ifdef ARROW_SPAWNER_INVERSE_EN
        inv_d        = inv_q;
`endif

        if (!start_in) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: enter_gap = 1'b1;
                GAP: begin
                    if (gap_cnt_q == 9'd0) enter_launch = 1'b1;
                    else if (frame_tick)   gap_cnt_d = gap_cnt_q - 9'd1;
                end
                // The downstream stage may still present a stale hit here, so it is ignored.
                LAUNCH: begin
                    if (launch_clk_q) begin
                        state_d      = FLIGHT;
                        flight_cnt_d = 8'd0;
                    end else begin
                        launch_clk_d = 1'b1;
                    end
                end
                FLIGHT: begin
                    if (arrow.arrow_hit_in || (flight_cnt_q == FLIGHT_MAX)) enter_gap = 1'b1;
                    else if (frame_tick) flight_cnt_d = flight_cnt_q + 8'd1;
                end
                default: state_d = IDLE;
            endcase
        end

        if (enter_gap) begin
            state_d   = GAP;
            valid_d   = 1'b0;
            gap_cnt_d = gap_len;
            dir_d     = lfsr_q[1:0];
            spawn_d   = spawn_q + 8'd1;
        end

        if (enter_launch) begin
            state_d      = LAUNCH;
            valid_d      = 1'b1;
            launch_clk_d = 1'b0;
            if (launch_mod_q == SPEEDUP_LAST) begin
                launch_mod_d = 8'd0;
                if (speed_q != SPEED_TOP) speed_d = speed_q + 3'd1;
            end else begin
                launch_mod_d = launch_mod_q + 8'd1;
            end
`ifdef ARROW_SPAWNER_INVERSE_EN
            // dir_q holds the lfsr bits latched at GAP entry, i.e. this arrow's direction.
            inv_d = (spawn_q[1:0] == 2'b11) && (dir_q == 2'b00);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            lfsr_q       <= LFSR_SEED;
            gap_cnt_q    <= 9'd0;
            flight_cnt_q <= 8'd0;
            launch_clk_q <= 1'b0;
            launch_mod_q <= 8'd0;
            valid_q      <= 1'b0;
            dir_q        <= 2'b00;
            speed_q      <= 3'd1;
            spawn_q      <= 8'd0;
`ifdef ARROW_SPAWNER_INVERSE_EN
            inv_q        <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates so every flop samples the same pre-edge values.
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            gap_cnt_q    <= gap_cnt_d;
            flight_cnt_q <= flight_cnt_d;
            launch_clk_q <= launch_clk_d;
            launch_mod_q <= launch_mod_d;
            valid_q      <= valid_d;
            dir_q        <= dir_d;
            speed_q      <= speed_d;
            spawn_q      <= spawn_d;
`ifdef ARROW_SPAWNER_INVERSE_EN
            inv_q        <= inv_d;
`endif
        end
    end

    assign arrow.valid_out     = valid_q;
    assign arrow.direction_out = dir_q;
    assign arrow.speed_out     = speed_q;
`ifdef ARROW_SPAWNER_INVERSE_EN
    assign arrow.inversed_out  = inv_q;
`else
    assign arrow.inversed_out  = 1'b0;
`endif
    assign spawn_count = spawn_q;

endmodule
